// File: rtl/lfsr_seq_monitor.sv
// ----------------------------------------------------------------------------
// lfsr_seq_monitor
// Receive-side monitor for an LFSR word stream. It seeds its prediction from
// the first nonzero word, verifies LOCK_CNT consecutive predictions, then
// declares lock and flywheels. While locked it flags and counts word errors
// and drops lock after UNLOCK_CNT consecutive bad words.
//
// Optional feature: define LFSR_MON_STATS_EN to add o_word_count (valid words
// seen while locked) and o_lock_loss (LOCKED->SEARCH transitions), both
// saturating. Without the macro those ports do not exist.
// ----------------------------------------------------------------------------
module lfsr_seq_monitor #(
   parameter int                    LFSR_WIDTH = 8,
   parameter logic [LFSR_WIDTH-1:0] TAPS       = 8'hB8,
   parameter int                    LOCK_CNT   = 4,
   parameter int                    UNLOCK_CNT = 3,
   parameter int                    ERR_W      = 16
) (
   input  logic                  clk,
   input  logic                  i_reset,
   input  logic [LFSR_WIDTH-1:0] i_LFSR,
   input  logic                  i_valid,
   input  logic                  i_clear,
`ifdef LFSR_MON_STATS_EN
   output logic [ERR_W-1:0]      o_word_count,
   output logic [7:0]            o_lock_loss,
`endif
   output logic                  o_lock,
   output logic                  o_err,
   output logic [ERR_W-1:0]      o_err_count
);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

   logic [1:0]            state_q,   state_d;
   logic [LFSR_WIDTH-1:0] pred_q,    pred_d;
   logic [3:0]            good_q,    good_d;
   logic [3:0]            bad_q,     bad_d;
   logic                  lock_q,    lock_d;
   logic                  err_q,     err_d;
   logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
`ifdef LFSR_MON_STATS_EN
   logic [ERR_W-1:0]      word_cnt_q, word_cnt_d;
   logic [7:0]            loss_cnt_q, loss_cnt_d;
`endif

   logic word_zero;
   logic match;
   logic [3:0] good_inc;
   logic [3:0] bad_inc;

   // Generator step: shift left, feedback is the parity of the tapped bits.
   function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
      return {s[LFSR_WIDTH-2:0], ^(s & TAPS)};
   endfunction

   assign word_zero = (i_LFSR == '0);
   // An all-zero word is an LFSR lock-up state, so it never counts as a match.
   assign match     = !word_zero && (i_LFSR == pred_q);
   assign good_inc  = good_q + 4'd1;
   assign bad_inc   = bad_q + 4'd1;

   // Next-state logic: search / verify / locked tracking plus error bookkeeping.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      pred_d    = pred_q;
      good_d    = good_q;
      bad_d     = bad_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
`ifdef LFSR_MON_STATS_EN
      word_cnt_d = word_cnt_q;
      loss_cnt_d = loss_cnt_q;
`endif

      if (i_valid) begin
         case (state_q)
            ST_SEARCH: begin
               if (!word_zero) begin
                  pred_d  = lfsr_next(i_LFSR);
                  good_d  = 4'd0;
                  state_d = ST_VERIFY;
               end
            end

            ST_VERIFY: begin
               if (match) begin
                  pred_d = lfsr_next(pred_q);
                  if (good_inc == LOCK_N) begin
                     state_d = ST_LOCKED;
                     good_d  = 4'd0;
                     bad_d   = 4'd0;
                  end else begin
                     good_d = good_inc;
                  end
               end else if (!word_zero) begin
                  // Wrong guess: restart verification from this word.
                  pred_d = lfsr_next(i_LFSR);
                  good_d = 4'd0;
               end else begin
                  state_d = ST_SEARCH;
                  good_d  = 4'd0;
               end
            end

            ST_LOCKED: begin
               // Flywheel: keep our own prediction regardless of what arrived.
               pred_d = lfsr_next(pred_q);
`ifdef LFSR_MON_STATS_EN
               if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
`endif
               if (match) begin
                  bad_d = 4'd0;
               end else begin
                  err_d = 1'b1;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                  if (bad_inc == UNLOCK_N) begin
                     state_d = ST_SEARCH;
                     bad_d   = 4'd0;
                     good_d  = 4'd0;
`ifdef LFSR_MON_STATS_EN
                     if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
`endif
                  end else begin
                     bad_d = bad_inc;
                  end
               end
            end

            default: begin
               state_d = ST_SEARCH;
               good_d  = 4'd0;
               bad_d   = 4'd0;
            end
         endcase
      end

      // Clear acts on the counters only; the lock decision above stands.
      if (i_clear) begin
         err_cnt_d = '0;
         bad_d     = 4'd0;
`ifdef LFSR_MON_STATS_EN
         word_cnt_d = '0;
         loss_cnt_d = '0;
`endif
      end

      lock_d = (state_d == ST_LOCKED);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ST_SEARCH;
         pred_q    <= '0;
         good_q    <= 4'd0;
         bad_q     <= 4'd0;
         lock_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
`ifdef LFSR_MON_STATS_EN
         word_cnt_q <= '0;
         loss_cnt_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         pred_q    <= pred_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         lock_q    <= lock_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
`ifdef LFSR_MON_STATS_EN
         word_cnt_q <= word_cnt_d;
         loss_cnt_q <= loss_cnt_d;
`endif
      end
   end

   assign o_lock      = lock_q;
   assign o_err       = err_q;
   assign o_err_count = err_cnt_q;
`ifdef LFSR_MON_STATS_EN
   assign o_word_count = word_cnt_q;
   assign o_lock_loss  = loss_cnt_q;
`endif

endmodule
